// File: rtl/duck_game_ctrl.sv
// Per-round duck hunt sequencer: lives/score/ammo bookkeeping, duck mode control
// and scope-centre hit detection on each trigger press.
module duck_game_ctrl #(
  parameter int START_LIVES   = 3,
  parameter int MAX_LIVES     = 5,
  parameter int AMMO          = 3,
  parameter int FLY_FRAMES    = 600,
  parameter int HIT_FRAMES    = 30,
  parameter int FALL_FRAMES   = 60,
  parameter int ESCAPE_FRAMES = 60,
  parameter int DUCK_W        = 80,
  parameter int DUCK_H        = 80,
  parameter int SCOPE_OFF     = 30,
  parameter int BONUS_HITS    = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       trigger,
  input  logic [9:0] Scope_X,
  input  logic [9:0] Scope_Y,
  input  logic [9:0] Duck_X,
  input  logic [9:0] Duck_Y,
  output logic [3:0] lives,
  output logic [7:0] score,
  output logic [1:0] ammo,
  output logic [2:0] game_state,
  output logic       duck_active,
  output logic       duck_falling,
  output logic       duck_escaping,
  output logic       respawn,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_START   = 3'd0,
    S_RESPAWN = 3'd1,
    S_FLY     = 3'd2,
    S_HIT     = 3'd3,
    S_FALL    = 3'd4,
    S_ESCAPE  = 3'd5,
    S_OVER    = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] lives_q, lives_d;
  logic [7:0] score_q, score_d;
  logic [1:0] ammo_q, ammo_d;
  logic [9:0] frame_cnt_q, frame_cnt_d;
  logic       trigger_q;
  logic       duck_active_q, duck_falling_q, duck_escaping_q;
  logic       respawn_q, game_over_q;

  logic        trig_edge;
  logic        timeout;
  logic [9:0]  frame_limit;
  logic [10:0] sx, sy, duck_x_end, duck_y_end;
  logic        hit;
  logic [7:0]  score_inc;
  logic        bonus;

  assign trig_edge = trigger & ~trigger_q;

  // 11-bit arithmetic keeps the box edges from wrapping near the screen edge
  assign sx         = {1'b0, Scope_X} + 11'(SCOPE_OFF);
  assign sy         = {1'b0, Scope_Y} + 11'(SCOPE_OFF);
  assign duck_x_end = {1'b0, Duck_X} + 11'(DUCK_W);
  assign duck_y_end = {1'b0, Duck_Y} + 11'(DUCK_H);
  assign hit = (sx >= {1'b0, Duck_X}) && (sx < duck_x_end) &&
               (sy >= {1'b0, Duck_Y}) && (sy < duck_y_end);

  // Score saturates at 255; once saturated no further bonus lives are granted
  assign score_inc = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
  assign bonus     = (score_q != 8'hFF) &&
                     ((score_inc % 8'(BONUS_HITS)) == 8'd0);

  always_comb begin
    frame_limit = 10'h3FF;
    case (state_q)
      S_FLY:    frame_limit = 10'(FLY_FRAMES - 1);
      S_HIT:    frame_limit = 10'(HIT_FRAMES - 1);
      S_FALL:   frame_limit = 10'(FALL_FRAMES - 1);
      S_ESCAPE: frame_limit = 10'(ESCAPE_FRAMES - 1);
      default:  frame_limit = 10'h3FF;
    endcase
  end

  assign timeout = frame_tick && (frame_cnt_q == frame_limit);

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    score_d = score_q;
    ammo_d  = ammo_q;
    case (state_q)
      S_START: begin
        if (trig_edge) state_d = S_RESPAWN;
      end
      S_RESPAWN: begin
        ammo_d  = 2'(AMMO);
        state_d = S_FLY;
      end
      S_FLY: begin
        // A shot in the same cycle as the timeout wins over the timeout
        if (trig_edge && (ammo_q != 2'd0)) begin
          ammo_d = ammo_q - 2'd1;
          if (hit) begin
            state_d = S_HIT;
            score_d = score_inc;
            if (bonus && (lives_q < 4'(MAX_LIVES))) lives_d = lives_q + 4'd1;
          end else if ((ammo_q == 2'd1) || timeout) begin
            state_d = S_ESCAPE;
          end
        end else if (timeout) begin
          state_d = S_ESCAPE;
        end
      end
      S_HIT: begin
        if (timeout) state_d = S_FALL;
      end
      S_FALL: begin
        if (timeout) state_d = S_RESPAWN;
      end
      S_ESCAPE: begin
        if (timeout) state_d = (lives_q == 4'd0) ? S_OVER : S_RESPAWN;
      end
      S_OVER: begin
        if (trig_edge) begin
          state_d = S_RESPAWN;
          lives_d = 4'(START_LIVES);
          score_d = 8'd0;
        end
      end
      default: state_d = S_START;
    endcase

    if ((state_d == S_ESCAPE) && (state_q != S_ESCAPE) && (lives_d != 4'd0))
      lives_d = lives_d - 4'd1;

    if (state_d != state_q)   frame_cnt_d = 10'd0;
    else if (frame_tick)      frame_cnt_d = frame_cnt_q + 10'd1;
    else                      frame_cnt_d = frame_cnt_q;
  end

  // Mode outputs are registered from the next state so they line up with game_state
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q         <= S_START;
      lives_q         <= 4'(START_LIVES);
      score_q         <= 8'd0;
      ammo_q          <= 2'(AMMO);
      frame_cnt_q     <= 10'd0;
      trigger_q       <= 1'b0;
      duck_active_q   <= 1'b0;
      duck_falling_q  <= 1'b0;
      duck_escaping_q <= 1'b0;
      respawn_q       <= 1'b0;
      game_over_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      lives_q         <= lives_d;
      score_q         <= score_d;
      ammo_q          <= ammo_d;
      frame_cnt_q     <= frame_cnt_d;
      trigger_q       <= trigger;
      duck_active_q   <= (state_d == S_FLY) || (state_d == S_HIT) ||
                         (state_d == S_FALL) || (state_d == S_ESCAPE);
      duck_falling_q  <= (state_d == S_FALL);
      duck_escaping_q <= (state_d == S_ESCAPE);
      respawn_q       <= (state_d == S_RESPAWN);
      game_over_q     <= (state_d == S_OVER);
    end
  end

  assign lives         = lives_q;
  assign score         = score_q;
  assign ammo          = ammo_q;
  assign game_state    = state_q;
  assign duck_active   = duck_active_q;
  assign duck_falling  = duck_falling_q;
  assign duck_escaping = duck_escaping_q;
  assign respawn       = respawn_q;
  assign game_over     = game_over_q;

endmodule

// File: tb/tb_duck_game_ctrl.sv
// Directed scenario bench for duck_game_ctrl with hand-computed expectations.
module tb_duck_game_ctrl;

  logic       Clk = 1'b0;
  logic       Reset, frameTick, trigger;
  logic [9:0] scopeX, scopeY, duckX, duckY;
  logic [3:0] lives;
  logic [7:0] score;
  logic [1:0] ammo;
  logic [2:0] gameState;
  logic       duckActive, duckFalling, duckEscaping, respawn, gameOver;

  int checks = 0;
  int failures = 0;

  duck_game_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frameTick), .trigger(trigger),
    .Scope_X(scopeX), .Scope_Y(scopeY), .Duck_X(duckX), .Duck_Y(duckY),
    .lives(lives), .score(score), .ammo(ammo), .game_state(gameState),
    .duck_active(duckActive), .duck_falling(duckFalling),
    .duck_escaping(duckEscaping), .respawn(respawn), .game_over(gameOver)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic fire();
    trigger = 1'b0;
    step();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frameTick = 1'b0;
      step();
      frameTick = 1'b1;
      step();
      frameTick = 1'b0;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; trigger = 1'b0; frameTick = 1'b0;
    scopeX = 10'd0; scopeY = 10'd0; duckX = 10'd0; duckY = 10'd0;
    step(); step();
    Reset = 1'b0;
    checks++; if (gameState !== 3'd0) begin failures++; $display("[TB] FAIL reset_state actual=%0d required=0", gameState); end
    checks++; if (lives !== 4'd3) begin failures++; $display("[TB] FAIL reset_lives actual=%0d required=3", lives); end
    checks++; if (score !== 8'd0) begin failures++; $display("[TB] FAIL reset_score actual=%0d required=0", score); end
    checks++; if (ammo !== 2'd3) begin failures++; $display("[TB] FAIL reset_ammo actual=%0d required=3", ammo); end
    checks++; if ({duckActive, duckFalling, duckEscaping, respawn, gameOver} !== 5'b0) begin failures++; $display("[TB] FAIL reset_flags actual=%b required=00000", {duckActive, duckFalling, duckEscaping, respawn, gameOver}); end
  endtask

  task automatic test_start();
    fire();
    checks++; if (gameState !== 3'd1) begin failures++; $display("[TB] FAIL start_respawn_state actual=%0d required=1", gameState); end
    checks++; if (respawn !== 1'b1) begin failures++; $display("[TB] FAIL start_respawn_pulse actual=%b required=1", respawn); end
    checks++; if (duckActive !== 1'b0) begin failures++; $display("[TB] FAIL start_respawn_inactive actual=%b required=0", duckActive); end
    step();
    checks++; if (gameState !== 3'd2) begin failures++; $display("[TB] FAIL start_fly_state actual=%0d required=2", gameState); end
    checks++; if (respawn !== 1'b0) begin failures++; $display("[TB] FAIL start_respawn_end actual=%b required=0", respawn); end
    checks++; if ({lives, ammo, score} !== {4'd3, 2'd3, 8'd0}) begin failures++; $display("[TB] FAIL start_counters actual=%0d/%0d/%0d required=3/3/0", lives, ammo, score); end
    checks++; if (duckActive !== 1'b1) begin failures++; $display("[TB] FAIL start_active actual=%b required=1", duckActive); end
  endtask

  task automatic test_hit();
    scopeX = 10'd100; scopeY = 10'd100; duckX = 10'd90; duckY = 10'd95;
    fire();
    checks++; if ({gameState, score, ammo} !== {3'd3, 8'd1, 2'd2}) begin failures++; $display("[TB] FAIL hit_enter actual=%0d/%0d/%0d required=3/1/2", gameState, score, ammo); end
    fire();
    checks++; if ({gameState, ammo} !== {3'd3, 2'd2}) begin failures++; $display("[TB] FAIL hit_trigger_ignored actual=%0d/%0d required=3/2", gameState, ammo); end
    ticks(29);
    checks++; if (gameState !== 3'd3) begin failures++; $display("[TB] FAIL hit_29_ticks actual=%0d required=3", gameState); end
    ticks(1);
    checks++; if ({gameState, duckFalling} !== {3'd4, 1'b1}) begin failures++; $display("[TB] FAIL hit_to_fall actual=%0d/%b required=4/1", gameState, duckFalling); end
    ticks(59);
    checks++; if (gameState !== 3'd4) begin failures++; $display("[TB] FAIL fall_59_ticks actual=%0d required=4", gameState); end
    ticks(1);
    checks++; if ({gameState, respawn, duckFalling} !== {3'd1, 1'b1, 1'b0}) begin failures++; $display("[TB] FAIL fall_to_respawn actual=%0d/%b/%b required=1/1/0", gameState, respawn, duckFalling); end
    step();
    checks++; if ({gameState, ammo} !== {3'd2, 2'd3}) begin failures++; $display("[TB] FAIL hit_refly actual=%0d/%0d required=2/3", gameState, ammo); end
  endtask

  task automatic test_miss_escape();
    scopeX = 10'd400; scopeY = 10'd300; duckX = 10'd0; duckY = 10'd0;
    fire();
    checks++; if ({gameState, ammo} !== {3'd2, 2'd2}) begin failures++; $display("[TB] FAIL miss1 actual=%0d/%0d required=2/2", gameState, ammo); end
    fire();
    checks++; if ({gameState, ammo} !== {3'd2, 2'd1}) begin failures++; $display("[TB] FAIL miss2 actual=%0d/%0d required=2/1", gameState, ammo); end
    fire();
    checks++; if ({gameState, ammo, lives} !== {3'd5, 2'd0, 4'd2}) begin failures++; $display("[TB] FAIL miss3_escape actual=%0d/%0d/%0d required=5/0/2", gameState, ammo, lives); end
    checks++; if ({duckEscaping, duckActive} !== 2'b11) begin failures++; $display("[TB] FAIL escape_flags actual=%b required=11", {duckEscaping, duckActive}); end
    ticks(60);
    checks++; if ({gameState, lives} !== {3'd1, 4'd2}) begin failures++; $display("[TB] FAIL escape_to_respawn actual=%0d/%0d required=1/2", gameState, lives); end
    step();
  endtask

  task automatic test_held_trigger();
    trigger = 1'b1;
    for (int i = 0; i < 100; i++) step();
    trigger = 1'b0;
    step();
    checks++; if ({gameState, ammo} !== {3'd2, 2'd2}) begin failures++; $display("[TB] FAIL held_one_shot actual=%0d/%0d required=2/2", gameState, ammo); end
  endtask

  task automatic test_hit_boundary();
    duckX = 10'd100; duckY = 10'd100; scopeX = 10'd150; scopeY = 10'd100;
    fire();
    checks++; if ({gameState, ammo, score} !== {3'd2, 2'd1, 8'd1}) begin failures++; $display("[TB] FAIL edge_right_miss actual=%0d/%0d/%0d required=2/1/1", gameState, ammo, score); end
    scopeX = 10'd149;
    fire();
    checks++; if ({gameState, ammo, score} !== {3'd3, 2'd0, 8'd2}) begin failures++; $display("[TB] FAIL edge_right_hit actual=%0d/%0d/%0d required=3/0/2", gameState, ammo, score); end
    ticks(90);
    step();
    checks++; if ({gameState, ammo} !== {3'd2, 2'd3}) begin failures++; $display("[TB] FAIL edge_refly actual=%0d/%0d required=2/3", gameState, ammo); end
    scopeX = 10'd69;
    fire();
    checks++; if ({gameState, ammo} !== {3'd2, 2'd2}) begin failures++; $display("[TB] FAIL edge_left_miss actual=%0d/%0d required=2/2", gameState, ammo); end
  endtask

  task automatic test_timeout_over();
    ticks(599);
    checks++; if (gameState !== 3'd2) begin failures++; $display("[TB] FAIL fly_599_ticks actual=%0d required=2", gameState); end
    ticks(1);
    checks++; if ({gameState, lives} !== {3'd5, 4'd1}) begin failures++; $display("[TB] FAIL timeout_escape1 actual=%0d/%0d required=5/1", gameState, lives); end
    ticks(60);
    step();
    ticks(600);
    checks++; if ({gameState, lives} !== {3'd5, 4'd0}) begin failures++; $display("[TB] FAIL timeout_escape2 actual=%0d/%0d required=5/0", gameState, lives); end
    ticks(60);
    checks++; if ({gameState, gameOver, duckActive} !== {3'd6, 1'b1, 1'b0}) begin failures++; $display("[TB] FAIL over_state actual=%0d/%b/%b required=6/1/0", gameState, gameOver, duckActive); end
    fire();
    checks++; if ({gameState, lives, score, gameOver} !== {3'd1, 4'd3, 8'd0, 1'b0}) begin failures++; $display("[TB] FAIL over_restart actual=%0d/%0d/%0d/%b required=1/3/0/0", gameState, lives, score, gameOver); end
    step();
  endtask

  task automatic test_bonus();
    duckX = 10'd1000; duckY = 10'd500; scopeX = 10'd1000; scopeY = 10'd500;
    for (int k = 1; k <= 30; k++) begin
      fire();
      checks++; if ({gameState, score} !== {3'd3, 8'(k)}) begin failures++; $display("[TB] FAIL bonus_hit_%0d actual=%0d/%0d required=3/%0d", k, gameState, score, k); end
      if (k == 9)  begin checks++; if (lives !== 4'd3) begin failures++; $display("[TB] FAIL bonus_at9 actual=%0d required=3", lives); end end
      if (k == 10) begin checks++; if (lives !== 4'd4) begin failures++; $display("[TB] FAIL bonus_at10 actual=%0d required=4", lives); end end
      if (k == 20) begin checks++; if (lives !== 4'd5) begin failures++; $display("[TB] FAIL bonus_at20 actual=%0d required=5", lives); end end
      if (k == 30) begin checks++; if (lives !== 4'd5) begin failures++; $display("[TB] FAIL bonus_sat30 actual=%0d required=5", lives); end end
      ticks(90);
      step();
    end
  endtask

  task automatic test_shot_timeout();
    scopeX = 10'd400; scopeY = 10'd300; duckX = 10'd0; duckY = 10'd0;
    ticks(599);
    step();
    trigger = 1'b1; frameTick = 1'b1;
    step();
    trigger = 1'b0; frameTick = 1'b0;
    checks++; if ({gameState, ammo, lives} !== {3'd5, 2'd2, 4'd4}) begin failures++; $display("[TB] FAIL shot_timeout_escape actual=%0d/%0d/%0d required=5/2/4", gameState, ammo, lives); end
    ticks(60);
    step();
  endtask

  task automatic test_reset_mid_fall();
    scopeX = 10'd100; scopeY = 10'd100; duckX = 10'd90; duckY = 10'd95;
    fire();
    checks++; if ({gameState, score} !== {3'd3, 8'd31}) begin failures++; $display("[TB] FAIL prefall_hit actual=%0d/%0d required=3/31", gameState, score); end
    ticks(40);
    checks++; if (gameState !== 3'd4) begin failures++; $display("[TB] FAIL prefall_state actual=%0d required=4", gameState); end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    checks++; if ({gameState, lives, score, ammo} !== {3'd0, 4'd3, 8'd0, 2'd3}) begin failures++; $display("[TB] FAIL midfall_reset actual=%0d/%0d/%0d/%0d required=0/3/0/3", gameState, lives, score, ammo); end
    checks++; if ({duckActive, duckFalling, duckEscaping, respawn, gameOver} !== 5'b0) begin failures++; $display("[TB] FAIL midfall_reset_flags actual=%b required=00000", {duckActive, duckFalling, duckEscaping, respawn, gameOver}); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hit();
    test_miss_escape();
    test_held_trigger();
    test_hit_boundary();
    test_timeout_over();
    test_bonus();
    test_shot_timeout();
    test_reset_mid_fall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
